gpio_emio_arbiter: RTL and testbench
====================================

Name: gpio_emio_arbiter

Overview:
- Shares the PS EMIO GPIO output/tristate bus between N fabric requesters. Ownership is exclusive and granted round-robin.
- Sits between fabric masters (bit-bang engines, PWM, test logic) and the EMIO GPIO pin-buffer wrapper. It drives that wrapper's O/T inputs and receives its I outputs.
- Guarantees a tristated turnaround cycle between owners so no two masters ever drive pins back to back.
- Returns a 2-flop-synchronised copy of pin inputs to all requesters.

Parameters:
- N, 4, number of requesters (2..8).
- W, 48, GPIO signal width (48 for 7Z020 single-ended, 24 for 7Z010 single-ended or 7Z020 differential).
- TIMEOUT, 0, maximum ownership cycles before forced revoke; 0 disables.
- CW, 16, timeout counter width; TIMEOUT < 2^CW.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- req  in  N  request/hold ownership, one bit per requester.
- rel  in  N  one-cycle release pulse from the current owner.
- req_o  in  N*W  per-requester output data; requester k occupies [k*W +: W].
- req_t  in  N*W  per-requester tristate (1 = input, 0 = drive).
- gnt  out  N  one-hot ownership grant.
- busy  out  1  any gnt bit is high, or state is TURN.
- timeout_evt  out  1  one-cycle pulse on forced revoke.
- gpio_o  out  W  to EMIO GPIO_O[W-1:0].
- gpio_t  out  W  to EMIO GPIO_T[W-1:0].
- gpio_i  in  W  from EMIO GPIO_I[W-1:0].
- sync_i  out  W  gpio_i after two flops, broadcast to all requesters.

Behaviour:
- Reset values: gnt=0, busy=0, timeout_evt=0, gpio_o=0, gpio_t=all ones, sync_i=0, rr pointer=0, timeout counter=0, state=IDLE.
- Reset mid-ownership: the next edge forces all of the above. No further pin drive occurs after that edge.
- All outputs are registered.
- States:
  - IDLE: gpio_t all ones, gpio_o 0.
    - If any req bit is set, latch winner = first set req bit at or after the pointer (search wraps modulo N). Go to TURN.
    - If no req bit is set, stay in IDLE.
  - TURN: exactly one cycle, pins still tristated.
    - If req[winner] is still high, go to OWN and assert gnt[winner] on the entering edge.
    - If req[winner] has dropped, return to IDLE.
  - OWN: each cycle register gpio_o/gpio_t from the owner's slice, so pins lag req_o/req_t by one cycle.
    - Exit when rel[owner]=1, req[owner]=0, or the counter reaches TIMEOUT (TIMEOUT≠0).
    - On the exit edge: gnt=0, gpio_t=all ones, gpio_o=0, pointer=(owner+1) mod N, state=IDLE.
    - On a timeout exit, timeout_evt=1 for that one cycle.
- Latency:
  - req asserted in IDLE at cycle c gives gnt high at c+2; first driven pin value appears at c+3.
  - Minimum handover between owners is two tristated cycles (IDLE, TURN).
- Timeout counter:
  - Clears on entry to OWN and increments each OWN cycle.
  - Revoke fires when count == TIMEOUT-1, so the owner holds exactly TIMEOUT cycles.
- Simultaneous events:
  - rel and timeout in the same cycle is treated as a normal release; timeout_evt stays 0.
  - rel/req changes from non-owners are ignored during OWN and TURN.
  - The rel pin of a non-owner is never acted upon.
- A requester that holds req after its own release is reconsidered only in the next IDLE cycle, with the rotated pointer.
- sync_i runs independently of the FSM.

Decomposition:
- Package gpio_emio_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_TURN=2'd1, ST_OWN=2'd2;
  - the default tristate value TRI_ALL (all ones).
- One sub-module: gpio_rr_pick. It is purely combinational: req vector plus pointer in, winner index and valid out. It is reused by other codebase arbiters.

Test Plan:
- Reset then idle: after reset deassert, gpio_t=all ones, gpio_o=0, gnt=0 for 20 cycles with req=0.
- Single owner, N=4, W=48:
  - req[2]=1 at cycle 10 → gnt=4'b0100 at cycle 12.
  - req_o slice 2 = 48'hA5A5_0000_FFFF with req_t slice 2 = 0 → appears on gpio_o/gpio_t at cycle 13.
  - rel[2] pulse → gnt=0 and gpio_t=all ones on the next cycle.
- Round-robin fairness:
  - req=4'b1111 held, each owner releases after 3 cycles → grant order 0,1,2,3,0.
  - Exactly 2 tristated cycles between consecutive grants.
- Timeout with TIMEOUT=5:
  - Requester 1 holds req and never releases → gnt[1] high for exactly 5 cycles.
  - timeout_evt pulses once; next grant goes to requester 2 if it is requesting.
- TURN abort: req[3] high for one cycle only → TURN entered, then IDLE, gnt never asserted, pins stay tristated.
- Synchronous reset while requester 0 drives gpio_t=0 → on the next edge gpio_t=all ones, gnt=0, pointer=0; sync_i follows gpio_i with a 2-cycle lag afterwards.

Source files
------------

// File: rtl/gpio_emio_pkg.sv
// gpio_emio_pkg
// Shared definitions for the EMIO GPIO arbiter: FSM state encoding and the
// all-ones tristate value (pins released / input mode).
package gpio_emio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } state_e;

  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] TRI_ALL = '1;

endpackage

// File: rtl/gpio_rr_pick.sv
// gpio_rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// after the pointer, wrapping modulo N.
//   req_i   : request vector
//   ptr_i   : search start index
//   idx_o   : winning index (0 when nothing is requested)
//   valid_o : at least one request bit is set
module gpio_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % N;
  endfunction

  // Walk offsets from far to near so the nearest request overwrites the rest.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[wrap_idx(int'(ptr_i), i)]) begin
        idx_o   = PW'(wrap_idx(int'(ptr_i), i));
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_emio_arbiter.sv
// gpio_emio_arbiter
// Round-robin owner of the PS EMIO GPIO O/T bus for N fabric requesters, with a
// tristated IDLE+TURN gap between owners and a 2-flop synchroniser on GPIO_I.
//   clk, reset       : clock, synchronous active-high reset
//   req, rel         : per-requester hold request and one-cycle release
//   req_o, req_t     : per-requester pin data / tristate, slice k at [k*W +: W]
//   gnt, busy        : one-hot grant; any grant or turnaround in progress
//   timeout_evt      : one-cycle pulse on forced revoke
//   gpio_o, gpio_t   : to EMIO GPIO_O / GPIO_T
//   gpio_i, sync_i   : from EMIO GPIO_I; synchronised copy to requesters
//
// state   | meaning
// IDLE    | pins tristated, choosing next owner from req
// TURN    | one tristated turnaround cycle, winner latched
// OWN     | winner's slice drives the pins, one cycle lag
module gpio_emio_arbiter
  import gpio_emio_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 48,
  parameter int TIMEOUT = 0,
  parameter int CW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   rel,
  input  logic [N*W-1:0] req_o,
  input  logic [N*W-1:0] req_t,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           timeout_evt,
  output logic [W-1:0]   gpio_o,
  output logic [W-1:0]   gpio_t,
  input  logic [W-1:0]   gpio_i,
  output logic [W-1:0]   sync_i
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] TRI_W = TRI_ALL[W-1:0];

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] winner_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  gnt_q;
  logic          busy_q;
  logic          tevt_q;
  logic [W-1:0]  gpio_o_q;
  logic [W-1:0]  gpio_t_q;
  logic [W-1:0]  sync1_q;
  logic [W-1:0]  sync2_q;

  logic [PW-1:0] pick_idx;
  logic          pick_valid;

  gpio_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  logic          own_rel;
  logic          own_drop;
  logic          own_tmo;
  logic          own_exit;
  logic [PW-1:0] ptr_next;

  assign own_rel  = rel[winner_q];
  assign own_drop = !req[winner_q];
  assign own_tmo  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign own_exit = own_rel || own_drop || own_tmo;
  assign ptr_next = (winner_q == PW'(N - 1)) ? '0 : winner_q + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      tevt_q   <= 1'b0;
      gpio_o_q <= '0;
      gpio_t_q <= TRI_W;
    end else begin
      tevt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          gnt_q    <= '0;
          gpio_o_q <= '0;
          gpio_t_q <= TRI_W;
          if (pick_valid) begin
            winner_q <= pick_idx;
            state_q  <= ST_TURN;
            busy_q   <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_TURN: begin
          if (req[winner_q]) begin
            gnt_q   <= N'(1) << winner_q;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_OWN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (own_exit) begin
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            gpio_o_q <= '0;
            gpio_t_q <= TRI_W;
            ptr_q    <= ptr_next;
            state_q  <= ST_IDLE;
            // A release or dropped request on the same cycle wins over the timer.
            tevt_q   <= own_tmo && !own_rel && !own_drop;
          end else begin
            gpio_o_q <= req_o[int'(winner_q)*W +: W];
            gpio_t_q <= req_t[int'(winner_q)*W +: W];
            cnt_q    <= cnt_q + CW'(1);
          end
        end
        default: begin
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          gpio_o_q <= '0;
          gpio_t_q <= TRI_W;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign timeout_evt = tevt_q;
  assign gpio_o      = gpio_o_q;
  assign gpio_t      = gpio_t_q;
  assign sync_i      = sync2_q;

endmodule

// File: tb/tb_gpio_emio_arbiter.sv
module tb_gpio_emio_arbiter;

  localparam int N  = 4;
  localparam int W  = 48;
  localparam int TO = 5;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   rel;
  logic [N*W-1:0] req_o;
  logic [N*W-1:0] req_t;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           timeout_evt;
  logic [W-1:0]   gpio_o;
  logic [W-1:0]   gpio_t;
  logic [W-1:0]   gpio_i;
  logic [W-1:0]   sync_i;

  gpio_emio_arbiter #(.N(N), .W(W), .TIMEOUT(TO), .CW(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rel         (rel),
    .req_o       (req_o),
    .req_t       (req_t),
    .gnt         (gnt),
    .busy        (busy),
    .timeout_evt (timeout_evt),
    .gpio_o      (gpio_o),
    .gpio_t      (gpio_t),
    .gpio_i      (gpio_i),
    .sync_i      (sync_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner / pending candidate as plain integers (-1 = none).
  int           m_owner = -1;
  int           m_cand  = -1;
  int           m_ptr   = 0;
  int           m_held  = 0;
  logic         m_tevt  = 1'b0;
  logic [W-1:0] m_o     = '0;
  logic [W-1:0] m_t     = '1;
  logic [W-1:0] m_s1    = '0;
  logic [W-1:0] m_s2    = '0;

  task automatic model_step();
    bit found;
    if (reset) begin
      m_owner = -1; m_cand = -1; m_ptr = 0; m_held = 0;
      m_tevt = 1'b0; m_o = '0; m_t = '1; m_s1 = '0; m_s2 = '0;
    end else begin
      m_s2   = m_s1;
      m_s1   = gpio_i;
      m_tevt = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        if (rel[m_owner] || !req[m_owner] || (TO != 0 && m_held == TO)) begin
          m_tevt  = !rel[m_owner] && req[m_owner];
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_o     = '0;
          m_t     = '1;
        end else begin
          m_o = req_o[m_owner*W +: W];
          m_t = req_t[m_owner*W +: W];
        end
      end else if (m_cand >= 0) begin
        if (req[m_cand]) begin
          m_owner = m_cand;
          m_held  = 0;
        end
        m_cand = -1;
      end else begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!found && req[(m_ptr + i) % N]) begin
            m_cand = (m_ptr + i) % N;
            found  = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One clock: model follows the edge, DUT outputs compared at the falling edge.
  task automatic tick();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    @(negedge clk);
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("gnt", gnt, eg);
    chk("busy", busy, (m_owner >= 0 || m_cand >= 0));
    chk("timeout_evt", timeout_evt, m_tevt);
    chk("gpio_o", gpio_o, m_o);
    chk("gpio_t", gpio_t, m_t);
    chk("sync_i", sync_i, m_s2);
    gpio_i = rnd_w();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int bad;
    int order[$];
    int exp_order[5];
    int gap;
    int own;
    int g1;
    int nte;
    int got2;
    int bcnt;
    logic [N-1:0] prev;

    reset = 1'b1; req = '0; rel = '0; req_o = '0; req_t = '1; gpio_i = '0;
    repeat (3) tick();
    reset = 1'b0;

    // quiet idle
    bad = 0;
    repeat (20) begin
      tick();
      if (gpio_t !== {W{1'b1}} || gpio_o !== '0 || gnt !== '0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // single owner, latency and release
    req_o[2*W +: W] = 48'hA5A5_0000_FFFF;
    req_t[2*W +: W] = '0;
    req = 4'b0100;
    tick();
    chk("so_turn_gnt", gnt, 4'b0000);
    tick();
    chk("so_gnt", gnt, 4'b0100);
    chk("so_gnt_pins_tri", gpio_t, {W{1'b1}});
    tick();
    chk("so_pin_o", gpio_o, 48'hA5A5_0000_FFFF);
    chk("so_pin_t", gpio_t, 48'h0);
    rel = 4'b0100;
    tick();
    rel = '0; req = '0;
    chk("so_rel_gnt", gnt, 4'b0000);
    chk("so_rel_t", gpio_t, {W{1'b1}});
    repeat (3) tick();

    // round-robin fairness: each owner releases after 3 cycles
    do_reset();
    for (int k = 0; k < N; k++) begin
      req_o[k*W +: W] = rnd_w();
      req_t[k*W +: W] = rnd_w();
    end
    req = '1; prev = '0; gap = 0; own = 0; bad = 0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      tick();
      rel = '0;
      if (gnt != '0) begin
        if (prev == '0) begin
          order.push_back(oh2i(gnt));
          if (order.size() > 1 && gap != 2) bad++;
          own = 0;
        end
        own++;
        if (own == 3) rel = gnt;
      end else begin
        if (prev != '0) gap = 0;
        gap++;
      end
      prev = gnt;
    end
    chk("rr_grants", order.size(), 5);
    chk("rr_gaps", bad, 0);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < order.size() && i < 5; i++) chk("rr_order", order[i], exp_order[i]);
    req = '0; rel = '0;
    repeat (3) tick();

    // forced revoke: requester 1 never releases
    do_reset();
    req = 4'b0110; g1 = 0; nte = 0; got2 = 0;
    for (int c = 0; c < 40 && got2 == 0; c++) begin
      tick();
      if (gnt[1]) g1++;
      if (timeout_evt) nte++;
      if (gnt == 4'b0100) got2 = 1;
    end
    chk("to_hold_cycles", g1, TO);
    chk("to_evt_count", nte, 1);
    chk("to_next_owner", got2, 1);
    req = '0;
    repeat (3) tick();

    // TURN abort
    do_reset();
    req = 4'b1000; bad = 0; bcnt = 0;
    tick();
    req = '0;
    if (busy) bcnt++;
    repeat (6) begin
      tick();
      if (gnt != '0 || gpio_t !== {W{1'b1}}) bad++;
      if (busy) bcnt++;
    end
    chk("abort_no_grant", bad, 0);
    chk("abort_busy_cycles", bcnt, 1);

    // reset while requester 0 drives, pointer returns to 0
    do_reset();
    req = 4'b0010; bad = 1;
    for (int c = 0; c < 10 && bad != 0; c++) begin
      tick();
      if (gnt == 4'b0010) bad = 0;
    end
    chk("mr_first_grant", bad, 0);
    rel = 4'b0010; req = '0;
    tick();
    rel = '0;
    req_t[0 +: W] = '0;
    req_o[0 +: W] = rnd_w();
    req = 4'b0001;
    repeat (3) tick();
    chk("mr_driving", gpio_t, 48'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_rst_t", gpio_t, {W{1'b1}});
    chk("mr_rst_gnt", gnt, 4'b0000);
    req = 4'b0110;
    repeat (2) tick();
    chk("mr_ptr_zero", gnt, 4'b0010);
    req = '0;
    repeat (4) tick();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if ($urandom_range(7) == 0) req[k] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          req[k] = 1'b1;
        end
        rel[k] = ($urandom_range(5) == 0);
        if ($urandom_range(3) == 0) begin
          req_o[k*W +: W] = rnd_w();
          req_t[k*W +: W] = rnd_w();
        end
      end
      reset = ($urandom_range(149) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
